// File: rtl/jtag_reg_ctrl_if.sv
// Register-bus interface between the JTAG command controller and a register slave.
// The master issues one req/ack transaction at a time. bus_rdata is valid with bus_ack.
interface jtag_reg_ctrl_if #(
    parameter int ADDR_WIDTH  = 2,
    parameter int JDATA_WIDTH = 32
);
    logic                   bus_req;
    logic                   bus_we;
    logic [ADDR_WIDTH-1:0]  bus_addr;
    logic [JDATA_WIDTH-1:0] bus_wdata;
    logic                   bus_ack;
    logic [JDATA_WIDTH-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/jtag_reg_ctrl.sv
// JTAG USER-chain register access controller (TCK domain).
// The controller owns the DR shift register and decodes {we, addr, wdata} at UPDATE-DR.
// It runs one req/ack bus transaction per accepted frame. At CAPTURE-DR it returns
// {ovr, tmo, busy, rdata_q}.
// Optional feature macro: JTAG_REG_CTRL_TIMEOUT_EN. When it is defined, a request that
// sees no bus_ack for TIMEOUT_CYCLES tck cycles is aborted. The abort sets tmo and
// loads all-ones read data.
module jtag_reg_ctrl #(
    parameter int JDATA_WIDTH    = 32,
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic tck,
    input  logic reset,
    input  logic sel,
    input  logic capture,
    input  logic shift,
    input  logic update,
    input  logic tdi,
    output logic tdo,
    output logic busy,
    jtag_reg_ctrl_if.master bus
);
    localparam int FW = 1 + ADDR_WIDTH + JDATA_WIDTH;

    if (ADDR_WIDTH < 2) begin : g_addr_width_chk
        $error("jtag_reg_ctrl: ADDR_WIDTH must be >= 2 to hold the status field");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
        $error("jtag_reg_ctrl: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [FW-1:0]          sr_r;
    logic [FW-1:0]          status_s;
    logic                   bus_req_r;
    logic                   bus_we_r;
    logic [ADDR_WIDTH-1:0]  bus_addr_r;
    logic [JDATA_WIDTH-1:0] bus_wdata_r;
    logic [JDATA_WIDTH-1:0] rdata_q_r;
    logic                   busy_r;
    logic                   ovr_r;
    logic                   tmo_s;
    logic                   cap_s;
    logic                   shf_s;
    logic                   upd_s;

    // All JTAG strobes are qualified by SEL. Capture wins over shift.
    assign cap_s = sel & capture;
    assign shf_s = sel & shift & ~capture;
    assign upd_s = sel & update;

`ifdef JTAG_REG_CTRL_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tmo_r;

    assign cnt_nxt_s = tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign tmo_s     = tmo_r;
`else
    assign tmo_s = 1'b0;
`endif

    // Status word presented at capture; bits above the flags read as zero.
    always_comb begin
        status_s                  = {FW{1'b0}};
        status_s[JDATA_WIDTH-1:0] = rdata_q_r;
        status_s[JDATA_WIDTH]     = busy_r;
        status_s[JDATA_WIDTH+1]   = tmo_s;
        status_s[JDATA_WIDTH+2]   = ovr_r;
    end

    // DR shift register: a capture loads the status snapshot, and a shift moves LSB-first toward tdo.
    always_ff @(posedge tck) begin
        if (reset) begin
            sr_r <= {FW{1'b0}};
        end else if (cap_s) begin
            sr_r <= status_s;
        end else if (shf_s) begin
            sr_r <= {tdi, sr_r[FW-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    // Transaction FSM with its registered bus outputs, read-data latch and sticky flags.
    always_ff @(posedge tck) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {ADDR_WIDTH{1'b0}};
            bus_wdata_r <= {JDATA_WIDTH{1'b0}};
            rdata_q_r   <= {JDATA_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            ovr_r       <= 1'b0;
`ifdef JTAG_REG_CTRL_TIMEOUT_EN
            tmo_r       <= 1'b0;
            tmo_cnt_r   <= {CNT_W{1'b0}};
`endif
        end else begin
            // Flags are read-to-clear at capture. The set events below are assigned later in this block, so they win.
            if (cap_s) begin
                ovr_r <= 1'b0;
`ifdef JTAG_REG_CTRL_TIMEOUT_EN
                tmo_r <= 1'b0;
`endif
            end
            // A frame that arrives while a transaction is in flight is dropped and flagged.
            if (upd_s && (state_r != ST_IDLE)) begin
                ovr_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (upd_s) begin
                        bus_we_r    <= sr_r[FW-1];
                        bus_addr_r  <= sr_r[FW-2:JDATA_WIDTH];
                        bus_wdata_r <= sr_r[JDATA_WIDTH-1:0];
                        bus_req_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_REQ;
`ifdef JTAG_REG_CTRL_TIMEOUT_EN
                        tmo_cnt_r   <= {CNT_W{1'b0}};
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        if (!bus_we_r) begin
                            rdata_q_r <= bus.bus_rdata;
                        end
                        bus_req_r <= 1'b0;
                        state_r   <= ST_DONE;
                    end
`ifdef JTAG_REG_CTRL_TIMEOUT_EN
                    else if (cnt_nxt_s == TMO_LIM) begin
                        bus_req_r <= 1'b0;
                        tmo_r     <= 1'b1;
                        rdata_q_r <= {JDATA_WIDTH{1'b1}};
                        state_r   <= ST_DONE;
                    end else begin
                        tmo_cnt_r <= cnt_nxt_s;
                    end
`else
                    else begin
                        state_r <= ST_REQ;
                    end
`endif
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    bus_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tdo           = sr_r[0];
    assign busy          = busy_r;
    assign bus.bus_req   = bus_req_r;
    assign bus.bus_we    = bus_we_r;
    assign bus.bus_addr  = bus_addr_r;
    assign bus.bus_wdata = bus_wdata_r;
endmodule

// File: tb/tb_jtag_reg_ctrl.sv
// Self-checking bench for jtag_reg_ctrl.
// The bench runs a directed sequence and a randomized transaction loop. Expected values
// come from a host-level model: the last read data, the sticky flags, and the capture word
// {ovr, tmo, busy, rdata}.
`timescale 1ns/1ps
module tb_jtag_reg_ctrl;
    localparam int DW  = 32;
    localparam int AW  = 2;
    localparam int FW  = 1 + AW + DW;
    localparam int TMO = 10;

    logic tck = 1'b0;
    logic reset, sel, capture, shift, update, tdi, tdo, busy;

    jtag_reg_ctrl_if #(.ADDR_WIDTH(AW), .JDATA_WIDTH(DW)) bus_if ();

    jtag_reg_ctrl #(.JDATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .tck(tck), .reset(reset), .sel(sel), .capture(capture), .shift(shift),
        .update(update), .tdi(tdi), .tdo(tdo), .busy(busy), .bus(bus_if.master)
    );

    always #5 tck = ~tck;

    int total = 0;
    int bad   = 0;

    // Host-level reference model
    logic [DW-1:0] rdata_m;
    logic          ovr_m;
    logic          tmo_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    // Shift a frame in LSB first and collect what comes out of tdo.
    task automatic shift_frame(input logic [FW-1:0] f, output logic [FW-1:0] o);
        sel   = 1'b1;
        shift = 1'b1;
        for (int i = 0; i < FW; i++) begin
            tdi  = f[i];
            o[i] = tdo;
            tick();
        end
        shift = 1'b0;
        tdi   = 1'b0;
    endtask

    // Capture, then shift the next frame in while checking the status word against the model.
    task automatic read_status(input string tag, input logic [FW-1:0] next_f);
        logic [FW-1:0] o;
        sel     = 1'b1;
        capture = 1'b1;
        tick();
        capture = 1'b0;
        shift_frame(next_f, o);
        check(tag, 64'(o), 64'({ovr_m, tmo_m, 1'b0, rdata_m}));
        ovr_m = 1'b0;
        tmo_m = 1'b0;
    endtask

    // Apply UPDATE and check the request that appears one cycle later.
    task automatic start_txn(input string tag, input logic [FW-1:0] f);
        sel    = 1'b1;
        update = 1'b1;
        tick();
        update = 1'b0;
        check({tag, "_req"},   64'(bus_if.bus_req), 64'(1'b1));
        check({tag, "_we"},    64'(bus_if.bus_we), 64'(f[FW-1]));
        check({tag, "_addr"},  64'(bus_if.bus_addr), 64'(f[FW-2:DW]));
        check({tag, "_wdata"}, 64'(bus_if.bus_wdata), 64'(f[DW-1:0]));
        check({tag, "_busy"},  64'(busy), 64'(1'b1));
    endtask

    // Hold the request for d cycles, acknowledge in the last one, and check the teardown timing.
    task automatic finish_txn(input string tag, input int d, input logic we, input logic [DW-1:0] rd);
        for (int k = 0; k < d - 1; k++) begin
            bus_if.bus_rdata = $urandom;
            check({tag, "_hold"}, 64'(bus_if.bus_req), 64'(1'b1));
            tick();
        end
        check({tag, "_hold"}, 64'(bus_if.bus_req), 64'(1'b1));
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rd;
        tick();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = $urandom;
        check({tag, "_reqdrop"}, 64'(bus_if.bus_req), 64'(1'b0));
        check({tag, "_busy1"},   64'(busy), 64'(1'b1));
        tick();
        check({tag, "_busy0"},   64'(busy), 64'(1'b0));
        if (!we) rdata_m = rd;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] f, nf, pat, o;
        logic          we_v;
        logic [AW-1:0] addr_v;
        logic [DW-1:0] data_v;
        int            d, n;

        reset = 1'b1; sel = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
        rdata_m = '0; ovr_m = 1'b0; tmo_m = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_tdo",   64'(tdo), 64'(1'b0));
        check("rst_req",   64'(bus_if.bus_req), 64'(1'b0));
        check("rst_busy",  64'(busy), 64'(1'b0));
        check("rst_we",    64'(bus_if.bus_we), 64'(1'b0));
        check("rst_addr",  64'(bus_if.bus_addr), 64'(1'b0));
        check("rst_wdata", 64'(bus_if.bus_wdata), 64'(1'b0));

        // Directed read of 0xDEADBEEF with the ack 3 cycles after the request.
        f = {1'b0, 2'b01, 32'h0000_0000};
        read_status("rst_status", f);
        start_txn("rd", f);
        finish_txn("rd", 3, 1'b0, 32'hDEAD_BEEF);

        // Directed write; the read data stays 0xDEADBEEF.
        f = {1'b1, 2'b10, 32'h1234_5678};
        read_status("rd_status", f);
        start_txn("wr", f);
        finish_txn("wr", 2, 1'b1, 32'hCAFE_F00D);
        read_status("wr_keeps_rdata", {FW{1'b0}});

        // Randomized reads and writes.
        for (int t = 0; t < 8; t++) begin
            we_v   = 1'($urandom_range(0, 1));
            addr_v = AW'($urandom);
            data_v = $urandom;
            f      = {we_v, addr_v, data_v};
            read_status("rnd_pre", f);
            start_txn("rnd", f);
            d = $urandom_range(1, 6);
            finish_txn("rnd", d, we_v, $urandom);
        end
        read_status("rnd_post", {FW{1'b0}});

        // Overrun: a second update while the ack is withheld.
        f = {1'b0, 2'b01, 32'h0};
        read_status("ovr_pre", f);
        start_txn("ovr", f);
        tick();
        nf = {1'b1, 2'b11, 32'h5555_AAAA};
        shift_frame(nf, o);
        update = 1'b1;
        tick();
        update = 1'b0;
        ovr_m  = 1'b1;
        check("ovr_req_kept", 64'(bus_if.bus_req), 64'(1'b1));
        check("ovr_we_kept",  64'(bus_if.bus_we), 64'(1'b0));
        check("ovr_addr_kept", 64'(bus_if.bus_addr), 64'(2'b01));
        check("ovr_wdata_kept", 64'(bus_if.bus_wdata), 64'(32'h0));
        finish_txn("ovr", 2, 1'b0, 32'h0BAD_F00D);
        read_status("ovr_flag_set", {FW{1'b0}});
        read_status("ovr_flag_clr", {FW{1'b0}});

        // With sel low, the strobes must not disturb sr, tdo or the bus.
        pat = {1'b1, 2'b10, 32'hA5C3_0F96};
        read_status("gate_pre", pat);
        sel = 1'b0;
        for (int c = 0; c < 20; c++) begin
            capture = 1'($urandom_range(0, 1));
            shift   = 1'($urandom_range(0, 1));
            update  = 1'($urandom_range(0, 1));
            tdi     = 1'($urandom_range(0, 1));
            tick();
            check("gate_tdo", 64'(tdo), 64'(pat[0]));
            check("gate_req", 64'(bus_if.bus_req), 64'(1'b0));
        end
        capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
        shift_frame({FW{1'b0}}, o);
        check("gate_sr", 64'(o), 64'(pat));

`ifdef JTAG_REG_CTRL_TIMEOUT_EN
        // Timeout: a request that is never acknowledged.
        f = {1'b0, 2'b11, 32'h0};
        read_status("tmo_pre", f);
        start_txn("tmo", f);
        n = 0;
        while (bus_if.bus_req && n < 100) begin
            n++;
            tick();
        end
        check("tmo_req_cycles", 64'(n), 64'(TMO));
        check("tmo_busy1", 64'(busy), 64'(1'b1));
        tick();
        check("tmo_busy0", 64'(busy), 64'(1'b0));
        tmo_m   = 1'b1;
        rdata_m = 32'hFFFF_FFFF;
        read_status("tmo_flag_set", {FW{1'b0}});
        read_status("tmo_flag_clr", {FW{1'b0}});
`endif

        // A reset during REQ: the request drops, and a later ack is ignored.
        f = {1'b0, 2'b10, 32'h0};
        read_status("rstreq_pre", f);
        start_txn("rstreq", f);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ovr_m = 1'b0; tmo_m = 1'b0; rdata_m = '0;
        check("rstreq_req",  64'(bus_if.bus_req), 64'(1'b0));
        check("rstreq_busy", 64'(busy), 64'(1'b0));
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h7777_1234;
        tick();
        bus_if.bus_ack   = 1'b0;
        check("rstreq_noreq", 64'(bus_if.bus_req), 64'(1'b0));
        read_status("rstreq_rdata", {FW{1'b0}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
